lsu_bank: RTL and testbench
===========================

// Module: lsu_bank
// PURPOSE
//  Per-core bank of THREADS load/store units; produces the packed lsu_state consumed by the core scheduler.
//  - Steps on the scheduler's core_state encoding.
//  - Issues per-thread valid/ready requests to the memory controller.
//  - Returns load data to the register files.
//  - Scheduler stalls in WAIT while any thread reports REQUESTING or WAITING.
// PARAMETERS
//  THREADS         4    thread/LSU count per core
//  ADDR_BITS       8    memory address width
//  DATA_BITS       8    memory data width
//  TIMEOUT_CYCLES  255  WAITING cycles before forced abort (LSU_TIMEOUT_EN only)
// PORTS
//  clk                       in   1                   clock
//  reset                     in   1                   synchronous, active-high
//  core_state                in   3                   scheduler state (REQUEST=3'b011, UPDATE=3'b110)
//  thread_enable             in   THREADS             per-thread active mask
//  decoded_mem_read_enable   in   1                   current instruction is LDR
//  decoded_mem_write_enable  in   1                   current instruction is STR
//  rs                        in   THREADS*ADDR_BITS   packed per-thread address
//  rt                        in   THREADS*DATA_BITS   packed per-thread store data
//  mem_read_valid            out  THREADS             read request valid
//  mem_read_address          out  THREADS*ADDR_BITS   read address
//  mem_read_ready            in   THREADS             read response ready
//  mem_read_data             in   THREADS*DATA_BITS   read data
//  mem_write_valid           out  THREADS             write request valid
//  mem_write_address         out  THREADS*ADDR_BITS   write address
//  mem_write_data            out  THREADS*DATA_BITS   write data
//  mem_write_ready           in   THREADS             write ack
//  lsu_state                 out  2*THREADS           thread i in bits [2i+1:2i]
//  lsu_out                   out  THREADS*DATA_BITS   latched load result
//  lsu_timeout               out  THREADS             sticky timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0; all threads IDLE.
//  - Per-thread FSM; lsu_state encoding: IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
//  - IDLE -> REQUESTING: when core_state==REQUEST, thread_enable[i]=1 and (read_en | write_en).
//    - Read has priority if both are set; the op is latched for the access.
//    - Otherwise stay IDLE.
//  - REQUESTING -> WAITING, one cycle:
//    - Assert mem_*_valid[i].
//    - Drive address from rs[i]; for a store, drive data from rt[i].
//    - Address/data held stable until ready.
//  - WAITING: when ready[i] is sampled high:
//    - valid <= 0.
//    - For a load, lsu_out[i] <= mem_read_data[i].
//    - State -> DONE.
//  - Minimum latency: 3 edges from the REQUEST-sampling edge to DONE.
//  - DONE -> IDLE: when core_state==UPDATE.
//  - lsu_out[i] holds until the next completed load.
//  - ready ignored in any state other than WAITING. Stores never modify lsu_out.
//  - Disabled thread stays IDLE with lsu_state=00, even mid-block.
//  - thread_enable and decode inputs are sampled only on the IDLE->REQUESTING edge; later changes have no effect.
//  - Reset mid-access: next cycle IDLE, valids 0, lsu_out cleared; a pending ready is dropped.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//    - Per-thread counter clears on entry to WAITING and increments each WAITING cycle.
//    - Count reaches TIMEOUT_CYCLES with no ready: valid <= 0, lsu_out[i] <= 0, lsu_timeout[i] <= 1 (sticky until reset), state -> DONE.
//    - ready in the same cycle as the limit wins: normal completion, no flag.
//  LSU_TIMEOUT_EN undefined:
//    - No counter; WAITING persists until ready.
//    - lsu_timeout tied 0.
// TESTING
//  1. Load, 4 threads, rs={8'h13,8'h12,8'h11,8'h10}, ready 1 cycle after valid with data=addr+1
//     -> lsu_out={14,13,12,11}; lsu_state 01 -> 10 -> 11; 00 after UPDATE.
//  2. Store, thread_enable=4'b0101, rt=8'hAA
//     -> write_valid only on threads 0,2, data AA, held until ready;
//     -> threads 1,3 keep lsu_state=00; lsu_out unchanged.
//  3. Staggered readys at 1,3,5,7 cycles
//     -> lsu_state shows 10 for each thread until its own ready, then 11;
//     -> 8'hFF (all 11) only after the last ready.
//  4. reset asserted while thread 0 is WAITING, then ready asserted
//     -> next cycle lsu_state=0, valid=0, lsu_out=0; ready ignored.
//  5. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted
//     -> DONE after 4 WAITING cycles; lsu_timeout[0]=1; lsu_out[0]=0.
//  6. read_en=write_en=1, or ready asserted while IDLE
//     -> read only; no write_valid; no state change from the stray ready.

Source files
------------

// File: rtl/lsu_bank.sv
// lsu_bank: per-core bank of THREADS load/store units.
// Each thread runs IDLE -> REQUESTING -> WAITING -> DONE, driven by the
// scheduler's core_state, and exposes its state packed into lsu_state.
// Optional feature macro: LSU_TIMEOUT_EN (aborts a WAITING access after
// TIMEOUT_CYCLES cycles without a ready; sets a sticky lsu_timeout bit).
module lsu_bank #(
  parameter int THREADS        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     core_state,
  input  logic [THREADS-1:0]             thread_enable,
  input  logic                           decoded_mem_read_enable,
  input  logic                           decoded_mem_write_enable,
  input  logic [THREADS*ADDR_BITS-1:0]   rs,
  input  logic [THREADS*DATA_BITS-1:0]   rt,
  output logic [THREADS-1:0]             mem_read_valid,
  output logic [THREADS*ADDR_BITS-1:0]   mem_read_address,
  input  logic [THREADS-1:0]             mem_read_ready,
  input  logic [THREADS*DATA_BITS-1:0]   mem_read_data,
  output logic [THREADS-1:0]             mem_write_valid,
  output logic [THREADS*ADDR_BITS-1:0]   mem_write_address,
  output logic [THREADS*DATA_BITS-1:0]   mem_write_data,
  input  logic [THREADS-1:0]             mem_write_ready,
  output logic [2*THREADS-1:0]           lsu_state,
  output logic [THREADS*DATA_BITS-1:0]   lsu_out,
  output logic [THREADS-1:0]             lsu_timeout
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_REQUESTING = 2'b01,
    S_WAITING    = 2'b10,
    S_DONE       = 2'b11
  } lsu_state_e;

  for (genvar g = 0; g < THREADS; g++) begin : g_lsu
    lsu_state_e             r_state;
    lsu_state_e             w_next;
    logic                   r_is_read;
    logic                   r_rd_valid;
    logic                   r_wr_valid;
    logic [ADDR_BITS-1:0]   r_rd_addr;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [DATA_BITS-1:0]   r_wr_data;
    logic [DATA_BITS-1:0]   r_out;
    logic                   w_start;
    logic                   w_ready;
    logic                   w_expire;

    assign w_start = (core_state == CORE_REQUEST) && thread_enable[g] &&
                     (decoded_mem_read_enable || decoded_mem_write_enable);
    assign w_ready = r_is_read ? mem_read_ready[g] : mem_write_ready[g];

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    // The count after this WAITING cycle would reach the limit; ready wins.
    assign w_expire = !w_ready && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign lsu_timeout[g] = r_timeout;

    // Waiting-cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == S_REQUESTING) begin
        r_cnt <= '0;
      end else if (r_state == S_WAITING) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_expire) r_timeout <= 1'b1;
      end
    end
`else
    assign w_expire       = 1'b0;
    assign lsu_timeout[g] = 1'b0;
`endif

    // Next-state logic for this thread's access FSM
    always_comb begin
      w_next = r_state;
      case (r_state)
        S_IDLE:       if (w_start) w_next = S_REQUESTING;
        S_REQUESTING: w_next = S_WAITING;
        S_WAITING:    if (w_ready || w_expire) w_next = S_DONE;
        S_DONE:       if (core_state == CORE_UPDATE) w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end

    // State register plus request/response datapath registers
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state    <= S_IDLE;
        r_is_read  <= 1'b0;
        r_rd_valid <= 1'b0;
        r_wr_valid <= 1'b0;
        r_rd_addr  <= '0;
        r_wr_addr  <= '0;
        r_wr_data  <= '0;
        r_out      <= '0;
      end else begin
        r_state <= w_next;
        case (r_state)
          S_IDLE: begin
            if (w_start) r_is_read <= decoded_mem_read_enable;
          end
          S_REQUESTING: begin
            if (r_is_read) begin
              r_rd_valid <= 1'b1;
              r_rd_addr  <= rs[g*ADDR_BITS +: ADDR_BITS];
            end else begin
              r_wr_valid <= 1'b1;
              r_wr_addr  <= rs[g*ADDR_BITS +: ADDR_BITS];
              r_wr_data  <= rt[g*DATA_BITS +: DATA_BITS];
            end
          end
          S_WAITING: begin
            if (w_ready) begin
              r_rd_valid <= 1'b0;
              r_wr_valid <= 1'b0;
              if (r_is_read) r_out <= mem_read_data[g*DATA_BITS +: DATA_BITS];
            end else if (w_expire) begin
              r_rd_valid <= 1'b0;
              r_wr_valid <= 1'b0;
              r_out      <= '0;
            end
          end
          default: ;
        endcase
      end
    end

    assign lsu_state[2*g +: 2]                      = r_state;
    assign mem_read_valid[g]                        = r_rd_valid;
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = r_rd_addr;
    assign mem_write_valid[g]                       = r_wr_valid;
    assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = r_wr_addr;
    assign mem_write_data[g*DATA_BITS +: DATA_BITS]    = r_wr_data;
    assign lsu_out[g*DATA_BITS +: DATA_BITS]           = r_out;
  end

endmodule

// File: tb/tb_lsu_bank.sv
// tb_lsu_bank: randomized self-checking bench for lsu_bank.
// Expected behaviour is derived per access from the edge count since the
// REQUEST edge and each thread's chosen response latency.
module tb_lsu_bank;
  localparam int T  = 4;
`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam logic [2:0] C_REQUEST = 3'b011;
  localparam logic [2:0] C_WAIT    = 3'b100;
  localparam logic [2:0] C_UPDATE  = 3'b110;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     core_state;
  logic [T-1:0]   thread_enable;
  logic           decoded_mem_read_enable;
  logic           decoded_mem_write_enable;
  logic [T*8-1:0] rs, rt;
  logic [T-1:0]   mem_read_valid, mem_read_ready;
  logic [T*8-1:0] mem_read_address, mem_read_data;
  logic [T-1:0]   mem_write_valid, mem_write_ready;
  logic [T*8-1:0] mem_write_address, mem_write_data;
  logic [2*T-1:0] lsu_state;
  logic [T*8-1:0] lsu_out;
  logic [T-1:0]   lsu_timeout;

  int vectors = 0;
  int miscompares = 0;

  int unsigned m_lat   [T];
  logic [7:0]  m_addr  [T];
  logic [7:0]  m_wdata [T];
  logic [7:0]  m_rdata [T];
  logic [7:0]  exp_out [T];
  logic [T-1:0] exp_to;

  always #5 clk = ~clk;

  lsu_bank #(.THREADS(T), .ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .thread_enable(thread_enable),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_timeout(lsu_timeout)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access through the whole bank: REQUEST, per-thread responses, UPDATE.
  task automatic run_access(input logic rd, input logic wr, input logic [T-1:0] en,
                            input bit stray, input string tag);
    bit act [T];
    bit to  [T];
    int done_e [T];
    int last;
    logic [1:0] es;
    bit ev_r, ev_w, r;
    last = 0;
    for (int i = 0; i < T; i++) begin
      act[i]    = en[i] && (rd || wr);
      to[i]     = 1'b0;
      done_e[i] = 3 + int'(m_lat[i]);
`ifdef LSU_TIMEOUT_EN
      if (m_lat[i] >= TO) begin
        to[i]     = 1'b1;
        done_e[i] = 2 + TO;
      end
`endif
      if (act[i] && done_e[i] > last) last = done_e[i];
    end
    core_state = C_REQUEST;
    thread_enable = en;
    decoded_mem_read_enable = rd;
    decoded_mem_write_enable = wr;
    for (int i = 0; i < T; i++) begin
      rs[i*8 +: 8] = m_addr[i];
      rt[i*8 +: 8] = m_wdata[i];
    end
    mem_read_ready = '0;
    mem_write_ready = '0;
    for (int n = 1; n <= last + 1; n++) begin
      step();
      for (int i = 0; i < T; i++) begin
        if (!act[i])            es = 2'b00;
        else if (n == 1)        es = 2'b01;
        else if (n < done_e[i]) es = 2'b10;
        else                    es = 2'b11;
        ev_r = act[i] && rd && n >= 2 && n < done_e[i];
        ev_w = act[i] && !rd && n >= 2 && n < done_e[i];
        vectors++;
        if (lsu_state[2*i +: 2] !== es) begin
          miscompares++;
          $display("FAIL %s state t%0d edge%0d: got %b want %b", tag, i, n, lsu_state[2*i +: 2], es);
        end
        vectors++;
        if (mem_read_valid[i] !== ev_r || mem_write_valid[i] !== ev_w) begin
          miscompares++;
          $display("FAIL %s valid t%0d edge%0d: got r%b w%b want r%b w%b", tag, i, n,
                   mem_read_valid[i], mem_write_valid[i], ev_r, ev_w);
        end
        if (ev_r) begin
          vectors++;
          if (mem_read_address[i*8 +: 8] !== m_addr[i]) begin
            miscompares++;
            $display("FAIL %s raddr t%0d: got %h want %h", tag, i, mem_read_address[i*8 +: 8], m_addr[i]);
          end
        end
        if (ev_w) begin
          vectors++;
          if (mem_write_address[i*8 +: 8] !== m_addr[i] || mem_write_data[i*8 +: 8] !== m_wdata[i]) begin
            miscompares++;
            $display("FAIL %s write t%0d: got a%h d%h want a%h d%h", tag, i,
                     mem_write_address[i*8 +: 8], mem_write_data[i*8 +: 8], m_addr[i], m_wdata[i]);
          end
        end
      end
      // Decode/enable/operand changes after sampling must not matter.
      if (n == 1) begin
        core_state = C_WAIT;
        thread_enable = T'($urandom);
        decoded_mem_read_enable = 1'($urandom);
        decoded_mem_write_enable = 1'($urandom);
      end
      if (n == 2) begin
        rs = {T{8'($urandom)}};
        rt = {T{8'($urandom)}};
      end
      for (int i = 0; i < T; i++) begin
        r = (act[i] && !to[i] && n == int'(m_lat[i]) + 2) || (stray && n == 1);
        mem_read_data[i*8 +: 8] = r ? m_rdata[i] : 8'($urandom);
        mem_read_ready[i]  = rd ? r : stray;
        mem_write_ready[i] = rd ? stray : r;
      end
    end
    mem_read_ready = '0;
    mem_write_ready = '0;
    for (int i = 0; i < T; i++) begin
      if (act[i] && to[i]) exp_out[i] = 8'h00;
      else if (act[i] && rd) exp_out[i] = m_rdata[i];
      if (act[i] && to[i]) exp_to[i] = 1'b1;
      vectors++;
      if (lsu_out[i*8 +: 8] !== exp_out[i]) begin
        miscompares++;
        $display("FAIL %s lsu_out t%0d: got %h want %h", tag, i, lsu_out[i*8 +: 8], exp_out[i]);
      end
    end
    vectors++;
    if (lsu_timeout !== exp_to) begin
      miscompares++;
      $display("FAIL %s timeout: got %b want %b", tag, lsu_timeout, exp_to);
    end
    core_state = C_UPDATE;
    step();
    core_state = 3'b000;
    vectors++;
    if (lsu_state !== '0 || mem_read_valid !== '0 || mem_write_valid !== '0) begin
      miscompares++;
      $display("FAIL %s after_update: got st%b rv%b wv%b want 0", tag, lsu_state, mem_read_valid, mem_write_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_state = 3'b000;
    thread_enable = '0;
    decoded_mem_read_enable = 1'b0;
    decoded_mem_write_enable = 1'b0;
    rs = '0; rt = '0;
    mem_read_ready = '0; mem_write_ready = '0; mem_read_data = '0;
    step();
    step();
    vectors++;
    if ({lsu_state, mem_read_valid, mem_write_valid, lsu_out, lsu_timeout,
         mem_read_address, mem_write_address, mem_write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got st%b out%h rv%b wv%b to%b want all 0",
               lsu_state, lsu_out, mem_read_valid, mem_write_valid, lsu_timeout);
    end
    reset = 1'b0;
    for (int i = 0; i < T; i++) exp_out[i] = 8'h00;
    exp_to = '0;
  endtask

  task automatic test_load_all();
    for (int i = 0; i < T; i++) begin
      m_addr[i]  = 8'h10 + 8'(i);
      m_rdata[i] = m_addr[i] + 8'h01;
      m_wdata[i] = 8'($urandom);
      m_lat[i]   = 1;
    end
    run_access(1'b1, 1'b0, 4'hF, 1'b0, "load_all");
  endtask

  task automatic test_store_partial();
    for (int i = 0; i < T; i++) begin
      m_addr[i]  = 8'($urandom);
      m_wdata[i] = 8'hAA;
      m_rdata[i] = 8'($urandom);
      m_lat[i]   = $urandom_range(0, 4);
    end
    run_access(1'b0, 1'b1, 4'b0101, 1'b0, "store_partial");
  endtask

  task automatic test_staggered();
    for (int i = 0; i < T; i++) begin
      m_addr[i]  = 8'($urandom);
      m_rdata[i] = 8'($urandom);
      m_lat[i]   = 2 * i + 1;
    end
    run_access(1'b1, 1'b0, 4'hF, 1'b0, "staggered");
  endtask

  task automatic test_random();
    logic rd, wr;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < T; i++) begin
        m_addr[i]  = 8'($urandom);
        m_wdata[i] = 8'($urandom);
        m_rdata[i] = 8'($urandom);
        m_lat[i]   = $urandom_range(0, 6);
      end
      rd = 1'($urandom);
      wr = 1'($urandom);
      run_access(rd, wr, T'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_priority_stray();
    mem_read_ready = '1;
    mem_write_ready = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (lsu_state !== '0 || mem_read_valid !== '0 || mem_write_valid !== '0) begin
        miscompares++;
        $display("FAIL idle_stray_ready: got st%b rv%b wv%b want 0", lsu_state, mem_read_valid, mem_write_valid);
      end
    end
    for (int i = 0; i < T; i++) begin
      m_addr[i]  = 8'($urandom);
      m_wdata[i] = 8'($urandom);
      m_rdata[i] = 8'($urandom);
      m_lat[i]   = $urandom_range(0, 3);
    end
    run_access(1'b1, 1'b1, 4'hF, 1'b1, "rd_priority");
  endtask

  task automatic test_reset_midaccess();
    core_state = C_REQUEST;
    thread_enable = 4'b0001;
    decoded_mem_read_enable = 1'b1;
    decoded_mem_write_enable = 1'b0;
    rs[7:0] = 8'h5C;
    step();
    core_state = C_WAIT;
    step();
    vectors++;
    if (lsu_state[1:0] !== 2'b10 || mem_read_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_waiting: got st%b rv%b want 10 1", lsu_state[1:0], mem_read_valid[0]);
    end
    reset = 1'b1;
    mem_read_ready[0] = 1'b1;
    mem_read_data[7:0] = 8'hE7;
    step();
    reset = 1'b0;
    for (int i = 0; i < T; i++) exp_out[i] = 8'h00;
    exp_to = '0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (lsu_state !== '0 || mem_read_valid !== '0 || lsu_out !== '0 || lsu_timeout !== '0) begin
        miscompares++;
        $display("FAIL midreset_clear: got st%b rv%b out%h to%b want 0", lsu_state, mem_read_valid, lsu_out, lsu_timeout);
      end
      step();
    end
    mem_read_ready = '0;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < T; i++) begin
      m_addr[i]  = 8'($urandom);
      m_rdata[i] = 8'($urandom);
      m_lat[i]   = (i == 0) ? 10 : 3;
    end
    run_access(1'b1, 1'b0, 4'hF, 1'b0, "timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_load_all();
    test_store_partial();
    test_staggered();
    test_priority_stray();
    test_random();
    test_reset_midaccess();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
